apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Shares the single APB master user-side interface (transfer / READ_WRITE / address / data in; PSLVERR / read data out) between NUM_REQ requesters. Each requester has a valid/ready request channel and a response strobe. Only one transfer is in flight at a time. Command fields are held stable for the full APB setup+access window, which the master's stability checks require. The block sits between the sequencing logic (or testbench agents) and the APB master instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 9, APB address width
DATA_W, 8, APB data width
HOLD_CYCLES, 2, cycles the command is held after the transfer pulse before the response is sampled (>=2)

Ports:
PCLK  in  1  clock; all state updates on the rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_rw  in  NUM_REQ  per-requester direction; 1=read, 0=write
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  DATA_W  read data; valid with rsp_valid; 0 for writes
rsp_err  out  1  PSLVERR sampled at completion; valid with rsp_valid
transfer  out  1  to master: start-of-transfer pulse
READ_WRITE  out  1  to master: 1=read, 0=write
apb_write_paddr  out  ADDR_W  to master: write address
apb_write_data  out  DATA_W  to master: write data
apb_read_paddr  out  ADDR_W  to master: read address
PSLVERR  in  1  from master: slave error
apb_read_data_out  in  DATA_W  from master: read data

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, round-robin pointer = 0, no pending owner.
- FSM states: IDLE, XFER, HOLD, RESP.
- IDLE:
  - Winner chosen combinationally from req_valid, starting at the pointer.
  - req_ready[winner] = 1. If req_valid == 0, req_ready = 0.
  - On handshake: capture owner index, rw, addr and wdata into registers; go to XFER.
  - Pointer becomes (winner+1) mod NUM_REQ.
- XFER (1 cycle): transfer=1; READ_WRITE=captured rw.
  - Read: apb_read_paddr = captured addr; write address and write data buses = 0.
  - Write: apb_write_paddr / apb_write_data = captured values; apb_read_paddr = 0.
  - Next state HOLD.
- HOLD (HOLD_CYCLES cycles, down-counter): transfer=0; READ_WRITE and buses unchanged from XFER. Counter reaching 0 -> RESP.
- RESP (1 cycle): buses still held.
  - rsp_valid[owner]=1; rsp_err=PSLVERR; rsp_rdata = apb_read_data_out for reads, 0 for writes.
  - Next state IDLE, where buses, READ_WRITE and transfer return to 0.
- Latency: handshake in cycle t -> transfer at t+1 -> rsp_valid at t+2+HOLD_CYCLES.
  - Minimum request spacing HOLD_CYCLES+3 cycles.
  - req_ready is 0 outside IDLE.
- A requester deasserting req_valid before handshake loses nothing; no request is ever dropped after acceptance.
- A request arriving at the same cycle as RESP is accepted in the following IDLE cycle.
- Pointer wrap: after winner NUM_REQ-1, the pointer returns to 0.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. No rsp_valid is issued for the aborted request.
- Illegal req_valid with X: not sanitised. Requesters must drive known values when valid.

Optional Feature:
APB_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest valid index always wins; pointer register removed.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum (IDLE, XFER, HOLD, RESP);
  - default ADDR_W/DATA_W constants;
  - READ/WRITE encoding localparams (1/0).
- One sub-module: apb_rr_pick. Inputs request vector and pointer; outputs one-hot grant and winner index. Purely combinational.
  - Holds the round-robin vs fixed-priority choice.
  - The top keeps the FSM, hold counter, capture registers and pointer.

Test Plan:
- Single write: req_valid=4'b0001, rw=0, addr=9'h01A, wdata=8'hA5 -> transfer pulse 1 cycle after handshake; write address/data held 9'h01A/8'hA5 through RESP; rsp_valid[0] at t+4 (HOLD_CYCLES=2), rsp_err=0.
- Single read: requester 2, rw=1, addr=9'h1F0, master returns 8'h3C -> apb_read_paddr=9'h1F0 held; rsp_rdata=8'h3C, rsp_valid=4'b0100.
- Contention: all four valid continuously -> grant order 0,1,2,3,0. With APB_ARB_FIXED_PRIO_EN -> 0,0,0.
- Error: PSLVERR=1 during RESP on a read to 9'h100 -> rsp_err=1 with rsp_valid; next transfer rsp_err=0.
- Reset mid-HOLD: PRESETn low during HOLD -> all outputs 0 immediately; no rsp_valid; first grant after release goes to requester 0.
- Back-to-back: requester 1 holds valid across RESP -> next transfer pulse exactly HOLD_CYCLES+3 cycles after the previous one.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational winner selection: round-robin from i_ptr by default,
// lowest-index-wins when APB_ARB_FIXED_PRIO_EN is defined.
module apb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

`ifdef APB_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_idx = '0;
    // Scan downward so the lowest valid index is the last (winning) write.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    int j;
    j     = 0;
    o_idx = '0;
    // Scan offsets downward so the closest valid requester at/after the pointer wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j]) o_idx = IDX_W'(j);
    end
  end
`endif

  assign o_grant = (|i_req) ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates NUM_REQ valid/ready requesters onto one APB master user interface.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         apb_read_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_ptr;
  logic [IDX_W-1:0]   w_win_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               w_hs;

  apb_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req  (req_valid),
    .i_ptr  (w_ptr),
    .o_grant(w_grant),
    .o_idx  (w_win_idx)
  );

  assign w_hs = (r_state == IDLE) && (|req_valid);

`ifdef APB_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)  r_ptr <= '0;
    else if (w_hs) r_ptr <= (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + 1'b1;
  end

  assign w_ptr = r_ptr;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) r_owner <= w_win_idx;
      if (r_state == XFER)                 r_cnt <= CNT_W'(HOLD_CYCLES - 1);
      else if (r_state == HOLD && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Command capture; only ever observed while the FSM is out of IDLE.
  always_ff @(posedge PCLK) begin
    if (w_hs) begin
      r_rw    <= req_rw[w_win_idx];
      r_addr  <= req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
      r_wdata <= req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = XFER;
      XFER:    w_state_nxt = HOLD;
      HOLD:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = '0;
    rsp_valid       = '0;
    rsp_rdata       = '0;
    rsp_err         = 1'b0;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_write_paddr = '0;
    apb_write_data  = '0;
    apb_read_paddr  = '0;
    if (r_state == IDLE && PRESETn) req_ready = w_grant;
    // Command buses stay stable from the transfer pulse through the response cycle.
    if (r_state != IDLE) begin
      READ_WRITE = r_rw;
      if (r_rw == RW_READ) begin
        apb_read_paddr = r_addr;
      end else begin
        apb_write_paddr = r_addr;
        apb_write_data  = r_wdata;
      end
    end
    if (r_state == XFER) transfer = 1'b1;
    if (r_state == RESP) begin
      rsp_valid = NUM_REQ'(1) << r_owner;
      rsp_err   = PSLVERR;
      rsp_rdata = (r_rw == RW_READ) ? apb_read_data_out : '0;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (NUM_REQ=4, HOLD_CYCLES=2).
module tb_apb_req_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 8;
  localparam int HOLD_CYCLES = 2;

  logic                      PCLK = 1'b0;
  logic                      PRESETn;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_rw, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, apb_write_data, apb_read_data_out;
  logic                      rsp_err, transfer, READ_WRITE, PSLVERR;
  logic [ADDR_W-1:0]         apb_write_paddr, apb_read_paddr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr),
    .PSLVERR(PSLVERR), .apb_read_data_out(apb_read_data_out)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic act, input logic rw,
                         input logic [8:0] a, input logic [7:0] d);
    chk({tag, ".rw"},     32'(READ_WRITE),      32'(act & rw));
    chk({tag, ".rpaddr"}, 32'(apb_read_paddr),  32'((act && rw)  ? a : 9'h0));
    chk({tag, ".wpaddr"}, 32'(apb_write_paddr), 32'((act && !rw) ? a : 9'h0));
    chk({tag, ".wdata"},  32'(apb_write_data),  32'((act && !rw) ? d : 8'h0));
  endtask

  task automatic set_req(input int i, input logic rw, input logic [8:0] a, input logic [7:0] d);
    req_rw[i] = rw;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // One isolated transfer; entered and left at a negedge with the FSM in IDLE.
  task automatic single(input string tag, input int i, input logic rw, input logic [8:0] a,
                        input logic [7:0] d, input logic [7:0] rd, input logic err);
    int t_xfer;
    set_req(i, rw, a, d);
    req_valid = 4'b0001 << i;
    PSLVERR = 1'b0;
    apb_read_data_out = 8'h00;
    #1 chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << i));
    @(negedge PCLK);
    req_valid = '0;
    t_xfer = cyc;
    #1 chk({tag, ".xfer"}, 32'(transfer), 32'd1);
    chk_bus({tag, ".xfer"}, 1'b1, rw, a, d);
    for (int h = 0; h < HOLD_CYCLES; h++) begin
      @(negedge PCLK);
      #1 chk({tag, ".hold.xfer"}, 32'(transfer), 32'd0);
      chk({tag, ".hold.rsp"}, 32'(rsp_valid), 32'd0);
      chk_bus({tag, ".hold"}, 1'b1, rw, a, d);
    end
    apb_read_data_out = rd;
    PSLVERR = err;
    @(negedge PCLK);
    #1 chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(4'b0001 << i));
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'(err));
    chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(rw ? rd : 8'h00));
    chk({tag, ".latency"},   32'(cyc - t_xfer), 32'(HOLD_CYCLES + 1));
    chk_bus({tag, ".resp"}, 1'b1, rw, a, d);
    @(negedge PCLK);
    PSLVERR = 1'b0;
    apb_read_data_out = 8'h00;
    #1 chk({tag, ".idle.rsp"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".idle.xfer"}, 32'(transfer), 32'd0);
    chk_bus({tag, ".idle"}, 1'b0, 1'b0, 9'h0, 8'h0);
  endtask

  // Requesters in mask stay valid continuously; seq holds expected winners, one nibble each.
  task automatic stream(input string tag, input logic [3:0] mask, input int n, input logic [19:0] seq);
    int t_prev;
    int e;
    t_prev = 0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 9'h040 + 9'(i), 8'h50 + 8'(i));
    req_valid = mask;
    for (int g = 0; g < n; g++) begin
      e = int'(seq[g*4 +: 4]);
      #1 chk({tag, ".grant"}, 32'(req_ready), 32'(4'b0001 << e));
      @(negedge PCLK);
      if (g == n - 1) req_valid = '0;
      #1 chk({tag, ".xfer"}, 32'(transfer), 32'd1);
      chk({tag, ".wpaddr"}, 32'(apb_write_paddr), 32'(9'h040 + 9'(e)));
      chk({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
      if (g > 0) chk({tag, ".spacing"}, 32'(cyc - t_prev), 32'(HOLD_CYCLES + 3));
      t_prev = cyc;
      repeat (HOLD_CYCLES) @(negedge PCLK);
      @(negedge PCLK);
      #1 chk({tag, ".rsp"}, 32'(rsp_valid), 32'(4'b0001 << e));
      @(negedge PCLK);
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    PSLVERR = 1'b0;
    apb_read_data_out = '0;
    repeat (2) @(negedge PCLK);
    #1 chk("rst.xfer", 32'(transfer), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.rsp", 32'(rsp_valid), 32'd0);
    chk("rst.err", 32'(rsp_err), 32'd0);
    chk_bus("rst", 1'b0, 1'b0, 9'h0, 8'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    single("wr0", 0, 1'b0, 9'h01A, 8'hA5, 8'hFF, 1'b0);
    single("rd2", 2, 1'b1, 9'h1F0, 8'h00, 8'h3C, 1'b0);
    single("err", 1, 1'b1, 9'h100, 8'h00, 8'h5A, 1'b1);
    single("after_err", 3, 1'b0, 9'h0F3, 8'hC3, 8'hFF, 1'b0);

`ifdef APB_ARB_FIXED_PRIO_EN
    stream("contend", 4'b1111, 5, 20'h00000);
`else
    stream("contend", 4'b1111, 5, 20'h03210);
`endif
    stream("b2b", 4'b0010, 2, 20'h00011);

    // Abort an in-flight read from its HOLD phase.
    set_req(2, 1'b1, 9'h155, 8'h00);
    req_valid = 4'b0100;
    #1 chk("abort.grant", 32'(req_ready), 32'h4);
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK);
    PSLVERR = 1'b1;
    apb_read_data_out = 8'hAA;
    req_valid = 4'b1111;
    PRESETn = 1'b0;
    #1 chk("abort.xfer", 32'(transfer), 32'd0);
    chk("abort.ready", 32'(req_ready), 32'd0);
    chk("abort.rsp", 32'(rsp_valid), 32'd0);
    chk("abort.err", 32'(rsp_err), 32'd0);
    chk("abort.rdata", 32'(rsp_rdata), 32'd0);
    chk_bus("abort", 1'b0, 1'b0, 9'h0, 8'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      #1 chk("abort.no_rsp", 32'(rsp_valid), 32'd0);
    end
    PSLVERR = 1'b0;
    apb_read_data_out = 8'h00;
    PRESETn = 1'b1;
    #1 chk("post_rst.grant", 32'(req_ready), 32'h1);
    @(negedge PCLK);
    req_valid = '0;
    #1 chk("post_rst.xfer", 32'(transfer), 32'd1);
    chk("post_rst.wpaddr", 32'(apb_write_paddr), 32'h040);
    repeat (HOLD_CYCLES) @(negedge PCLK);
    @(negedge PCLK);
    #1 chk("post_rst.rsp", 32'(rsp_valid), 32'h1);
    @(negedge PCLK);
    #1 chk("post_rst.idle", 32'(transfer), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
